// File: rtl/count_stream_decoder_pkg.sv
// rtl/count_stream_decoder_pkg.sv - shared state and direction encodings for the count stream decoder
package count_stream_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/count_step_classify.sv
// rtl/count_step_classify.sv - classifies one observed count step as up, down or illegal
module count_step_classify #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_val,
  output logic             o_is_up,
  output logic             o_is_dn,
  output logic             o_is_bad
);

  logic [WIDTH-1:0] w_delta;

  // Modular difference makes both wrap directions fall out naturally.
  assign w_delta  = i_val - i_prev;
  assign o_is_up  = (w_delta == WIDTH'(1));
  assign o_is_dn  = (w_delta == {WIDTH{1'b1}});
  assign o_is_bad = ~(o_is_up | o_is_dn);

endmodule

// File: rtl/count_stream_decoder.sv
// rtl/count_stream_decoder.sv - recovers direction from an up/down count stream and tracks lock/health
module count_stream_decoder
  import count_stream_decoder_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_val,
  input  logic             clr_err,
  output logic             dir_out,
  output logic             dir_vld,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_run_inc;
  logic [WIDTH-1:0] r_prev;
  logic             r_have_prev;
  logic             r_dir_out;
  logic             r_dir_vld;
  logic             r_locked;
  logic             r_step_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_is_up;
  logic             w_is_dn;
  logic             w_is_bad;
  logic             w_eval;
  logic             w_bad_step;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .i_prev   (r_prev),
    .i_val    (in_val),
    .o_is_up  (w_is_up),
    .o_is_dn  (w_is_dn),
    .o_is_bad (w_is_bad)
  );

  // The very first sample after reset is only a reference, never a step.
  assign w_eval     = in_en & r_have_prev;
  assign w_bad_step = w_eval & w_is_bad;
  assign w_run_inc  = r_run_cnt + RUN_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= HUNT;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    if (w_eval) begin
      if (w_is_bad) begin
        w_state_nxt = HUNT;
        w_run_nxt   = '0;
      end else begin
        case (r_state)
          HUNT: begin
            w_run_nxt   = RUN_W'(1);
            w_state_nxt = (LOCK_LEN <= 1) ? LOCKED : SYNC;
          end
          SYNC: begin
            w_run_nxt = w_run_inc;
            if (w_run_inc >= RUN_W'(LOCK_LEN)) begin
              w_state_nxt = LOCKED;
            end
          end
          LOCKED: begin
            w_state_nxt = LOCKED;
          end
          default: begin
            w_state_nxt = HUNT;
            w_run_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_dir_out   <= DIR_UP;
      r_dir_vld   <= 1'b0;
      r_locked    <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_step_err <= 1'b0;
      r_locked   <= (w_state_nxt == LOCKED);
      if (in_en) begin
        r_prev      <= in_val;
        r_have_prev <= 1'b1;
        if (!r_have_prev) begin
          r_dir_vld <= 1'b0;
        end else if (w_is_bad) begin
          r_step_err <= 1'b1;
          r_dir_vld  <= 1'b0;
        end else if (w_is_up) begin
          r_dir_out <= DIR_UP;
          r_dir_vld <= 1'b1;
        end else if (w_is_dn) begin
          r_dir_out <= DIR_DN;
          r_dir_vld <= 1'b1;
        end
      end
      // A clear coinciding with an illegal step leaves that step counted.
      if (clr_err) begin
        r_err_cnt <= {{(ERR_W-1){1'b0}}, w_bad_step};
      end else if (w_bad_step && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign dir_out  = r_dir_out;
  assign dir_vld  = r_dir_vld;
  assign locked   = r_locked;
  assign step_err = r_step_err;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_count_stream_decoder.sv
// tb/tb_count_stream_decoder.sv - directed self-checking bench for count_stream_decoder
module tb_count_stream_decoder;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_en, clr_err;
  logic [2:0] in_val;
  logic       dir_out, dir_vld, locked, step_err;
  logic [7:0] err_cnt;

  logic       in_en2, clr_err2;
  logic [2:0] in_val2;
  logic       dir_out2, dir_vld2, locked2, step_err2;
  logic [1:0] err_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_stream_decoder #(.WIDTH(3), .LOCK_LEN(3), .ERR_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_en(in_en), .in_val(in_val), .clr_err(clr_err),
    .dir_out(dir_out), .dir_vld(dir_vld), .locked(locked), .step_err(step_err), .err_cnt(err_cnt)
  );

  count_stream_decoder #(.WIDTH(3), .LOCK_LEN(3), .ERR_W(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .in_en(in_en2), .in_val(in_val2), .clr_err(clr_err2),
    .dir_out(dir_out2), .dir_vld(dir_vld2), .locked(locked2), .step_err(step_err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] v);
    @(negedge clk);
    in_en  = 1'b1;
    in_val = v;
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic step2(input logic [2:0] v, input logic clr);
    @(negedge clk);
    in_en2   = 1'b1;
    in_val2  = v;
    clr_err2 = clr;
    @(posedge clk);
    #1;
    in_en2   = 1'b0;
    clr_err2 = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t2_val [8];
  logic       t2_dir [8];

  initial begin
    n_rst = 1'b0; in_en = 1'b0; in_val = '0; clr_err = 1'b0;
    in_en2 = 1'b0; in_val2 = '0; clr_err2 = 1'b0;
    t2_val = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
    t2_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_dir_out", dir_out, 0);
    chk("rst_dir_vld", dir_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    n_rst = 1'b1;

    // Lock-in on a plain up count
    step(3'd0);
    chk("t1_ref_vld", dir_vld, 0);
    chk("t1_ref_locked", locked, 0);
    step(3'd1);
    chk("t1_s1_dir", dir_out, 0);
    chk("t1_s1_vld", dir_vld, 1);
    chk("t1_s1_locked", locked, 0);
    step(3'd2);
    chk("t1_s2_locked", locked, 0);
    step(3'd3);
    chk("t1_s3_locked", locked, 1);
    step(3'd4);
    chk("t1_s4_locked", locked, 1);
    chk("t1_s4_vld", dir_vld, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Wraps in both directions and a direction change while locked
    step(3'd5);
    for (int i = 0; i < 8; i++) begin
      step(t2_val[i]);
      chk($sformatf("t2_dir_%0d", i), dir_out, t2_dir[i]);
      chk($sformatf("t2_vld_%0d", i), dir_vld, 1);
      chk($sformatf("t2_locked_%0d", i), locked, 1);
      chk($sformatf("t2_err_%0d", i), step_err, 0);
    end

    // Idle cycles hold status
    idle();
    idle();
    chk("hold_dir", dir_out, 1);
    chk("hold_vld", dir_vld, 1);
    chk("hold_locked", locked, 1);

    // Repeated value is illegal, then relock
    step(3'd4);
    step(3'd3);
    step(3'd2);
    step(3'd3);
    chk("t3_up_dir", dir_out, 0);
    step(3'd3);
    chk("t3_rep_err", step_err, 1);
    chk("t3_rep_locked", locked, 0);
    chk("t3_rep_vld", dir_vld, 0);
    chk("t3_rep_dir_hold", dir_out, 0);
    chk("t3_rep_cnt", err_cnt, 1);
    idle();
    chk("t3_idle_err", step_err, 0);
    chk("t3_idle_cnt", err_cnt, 1);
    step(3'd4);
    chk("t3_s4_err", step_err, 0);
    chk("t3_s4_vld", dir_vld, 1);
    chk("t3_s4_locked", locked, 0);
    step(3'd5);
    chk("t3_s5_locked", locked, 0);
    step(3'd6);
    chk("t3_relock", locked, 1);

    // Jump 1 -> 4 breaks lock; next legal step restarts the run at 1
    step(3'd7);
    step(3'd0);
    step(3'd1);
    step(3'd4);
    chk("t4_jump_err", step_err, 1);
    chk("t4_jump_locked", locked, 0);
    chk("t4_jump_cnt", err_cnt, 2);
    step(3'd5);
    chk("t4_s5_err", step_err, 0);
    chk("t4_s5_vld", dir_vld, 1);
    chk("t4_s5_locked", locked, 0);
    step(3'd6);
    chk("t4_s6_locked", locked, 0);
    step(3'd7);
    chk("t4_s7_locked", locked, 1);

    // Standalone clear
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    chk("clr_locked", locked, 1);

    // Saturation on the narrow counter, then clear coinciding with an error
    step2(3'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step2(3'd0, 1'b0);
      chk($sformatf("t5_cnt_%0d", k), err_cnt2, (k > 3) ? 3 : k);
      chk($sformatf("t5_err_%0d", k), step_err2, 1);
    end
    step2(3'd0, 1'b1);
    chk("t5_clr_cnt", err_cnt2, 1);
    chk("t5_clr_err", step_err2, 1);

    // Asynchronous reset mid-stream while locked
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_vld", dir_vld, 0);
    chk("t6_rst_dir", dir_out, 0);
    chk("t6_rst_cnt2", err_cnt2, 0);
    @(negedge clk);
    n_rst = 1'b1;
    step(3'd5);
    chk("t6_ref_vld", dir_vld, 0);
    chk("t6_ref_err", step_err, 0);
    chk("t6_ref_cnt", err_cnt, 0);
    step(3'd6);
    chk("t6_s6_dir", dir_out, 0);
    chk("t6_s6_vld", dir_vld, 1);
    chk("t6_s6_locked", locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
